mux_scan_ctrl: RTL

Scan controller that sits directly upstream of the 4-to-1 bit selector stage. On a start request it snapshots a 4-bit input word, then drives the selector's `data`, `valid` index and `flag` enable so that each bit is presented in turn, index 0 to 3. Each index is held for a programmable dwell time. It reports busy and done, and can optionally rescan continuously with a fresh snapshot each pass.

---
 rtl/mux_scan_ctrl.sv | 91 +++++++++
 1 files changed

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl: drives a 4-to-1 bit selector stage.
// A start request snapshots a 4-bit word. The block then presents bit
// indices 0..3 in order, holding each index for DWELL cycles. It reports
// busy and done. In continuous mode it rescans with a fresh snapshot on
// every pass.
module mux_scan_ctrl #(
   parameter int unsigned DWELL = 4  // cycles per index, legal range 1..255
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       cont,
   input  logic [3:0] din,
   output logic [3:0] data,
   output logic [1:0] valid,
   output logic       flag,
   output logic       busy,
   output logic       done
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_t;

   // Terminal value of the dwell counter; the counter never goes past it.
   localparam logic [7:0] LAST_CNT = 8'(DWELL - 1);

   state_t     state;
   logic [7:0] cnt;
   logic       dwell_end;

   // Final cycle of the current index's dwell window.
   assign dwell_end = (cnt == LAST_CNT);

   // Scan sequencer: the state machine and all registered outputs.
   // NOTE: Every register in this block, including the data snapshot,
   // is reset. This lets an async reset clear the outputs at once,
   // even in the middle of a scan.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         data  <= '0;
         valid <= '0;
         flag  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         // NOTE: Use non-blocking assignments throughout. The done
         // default below can then be overridden later in the same
         // block without creating ordering hazards.
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= SCAN;
                  data  <= din;
                  valid <= 2'd0;
                  cnt   <= '0;
                  flag  <= 1'b1;
                  busy  <= 1'b1;
               end
            end
            SCAN: begin
               if (!dwell_end) begin
                  cnt <= cnt + 8'd1;
               end else begin
                  cnt <= '0;
                  if (valid != 2'd3) begin
                     valid <= valid + 2'd1;
                  end else if (cont) begin
                     // Wrap into the next pass with no gap cycle.
                     data  <= din;
                     valid <= 2'd0;
                     done  <= 1'b1;
                  end else begin
                     // The scan is complete. Data keeps its last value.
                     state <= IDLE;
                     valid <= 2'd0;
                     flag  <= 1'b0;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
         endcase
      end
   end

endmodule
